// File: rtl/qc_row_shift_scheduler_if.sv
// Row-result handshake between the QC row shift scheduler and its consumer.
// The scheduler is the master: it presents row_valid/row_idx/row_data and
// holds them until the consumer raises row_ready.
interface qc_row_shift_scheduler_if #(
    parameter int MAXZ = 81,
    parameter int MB   = 12
);
    localparam int RW = $clog2(MB);

    logic            row_valid;
    logic            row_ready;
    logic [RW-1:0]   row_idx;
    logic [MAXZ-1:0] row_data;

    modport master (
        output row_valid,
        output row_idx,
        output row_data,
        input  row_ready
    );

    modport slave (
        input  row_valid,
        input  row_idx,
        input  row_data,
        output row_ready
    );
endinterface

// File: rtl/qc_row_shift_scheduler.sv
// Row-by-row sequencer for the pipelined circular shifter of a QC-LDPC
// datapath. Each base-matrix row is walked column by column; every non-null
// circulant with a legal shift is sent to the shifter, the shifter outputs are
// XOR-accumulated, and one Z-bit row result is handed out per row.
module qc_row_shift_scheduler #(
    parameter  int MAXZ = 81,
    parameter  int NB   = 24,
    parameter  int MB   = 12,
    localparam int SW   = $clog2(MAXZ),
    localparam int AW   = $clog2(MB * NB),
    localparam int CW   = $clog2(NB)
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SW:0]     z_size,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [AW-1:0]   bm_addr,
    input  logic [SW:0]     bm_rdata,
    output logic [CW-1:0]   blk_addr,
    input  logic [MAXZ-1:0] blk_rdata,
    output logic            sh_valid,
    output logic [MAXZ-1:0] sh_data,
    output logic [SW-1:0]   sh_shift,
    input  logic            sh_out_valid,
    input  logic [MAXZ-1:0] sh_out_data,
    qc_row_shift_scheduler_if.master row_if
);
    localparam int RW = $clog2(MB);
    localparam int FW = $clog2(NB + 1);
    localparam logic [FW-1:0] NB_F     = FW'(NB);
    localparam logic [RW-1:0] LAST_ROW = RW'(MB - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, OUT, DONE} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [SW:0]     z_reg;
    logic [RW-1:0]   row;
    logic [FW-1:0]   col;       // runs 0..NB; NB means all reads issued
    logic            pending;   // read data for the previous column returns now
    logic [FW-1:0]   inflight;
    logic [MAXZ-1:0] acc;

    logic issuing;
    logic entry_valid;
    logic entry_ok;
    logic last_return;
    logic drain_done;
    logic row_accept;

    assign issuing     = (state == ISSUE) && (col < NB_F);
    assign entry_valid = (state == ISSUE) && pending && bm_rdata[SW];
    assign entry_ok    = entry_valid && ({1'b0, bm_rdata[SW-1:0]} < z_reg);
    assign last_return = (state == ISSUE) && pending && (col == NB_F);
    assign drain_done  = (state == DRAIN) && (inflight == '0) && !sh_out_valid;
    assign row_accept  = (state == OUT) && row_if.row_valid && row_if.row_ready;

    // Read addresses are only driven while a column read is being issued.
    assign bm_addr  = issuing ? AW'(int'(row) * NB + int'(col)) : '0;
    assign blk_addr = issuing ? col[CW-1:0] : '0;

    // Shifter issue happens in the same cycle the entry and block return.
    assign sh_valid = entry_ok;
    assign sh_data  = entry_ok ? blk_rdata : '0;
    assign sh_shift = entry_ok ? bm_rdata[SW-1:0] : '0;

    assign busy = (state == ISSUE) || (state == DRAIN) || (state == OUT);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge CLK or negedge rst_n) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values, independent of block order.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: the default comes first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE:  if (start)       state_nxt = ISSUE;
            ISSUE: if (last_return) state_nxt = DRAIN;
            DRAIN: if (drain_done)  state_nxt = OUT;
            OUT:   if (row_accept)  state_nxt = (row != LAST_ROW) ? ISSUE : DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Column walk, in-flight tracking, accumulation and row-result registers.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            z_reg            <= '0;
            err              <= 1'b0;
            row              <= '0;
            col              <= '0;
            pending          <= 1'b0;
            inflight         <= '0;
            acc              <= '0;
            row_if.row_valid <= 1'b0;
            row_if.row_idx   <= '0;
            row_if.row_data  <= '0;
        end else begin
            pending <= issuing;
            if (issuing) col <= col + 1'b1;

            // Simultaneous issue and return leave the count unchanged; stale
            // returns with nothing outstanding must not wrap the counter.
            if (sh_valid && !sh_out_valid)
                inflight <= inflight + 1'b1;
            else if (!sh_valid && sh_out_valid && (inflight != '0))
                inflight <= inflight - 1'b1;

            if (entry_valid && !entry_ok) err <= 1'b1;

            // Clearing on pass and row start discards any stale shifter output.
            if ((state == IDLE) && start) begin
                z_reg <= z_size;
                err   <= 1'b0;
                row   <= '0;
                col   <= '0;
                acc   <= '0;
            end else if (row_accept) begin
                acc              <= '0;
                col              <= '0;
                row_if.row_valid <= 1'b0;
                if (row != LAST_ROW) row <= row + 1'b1;
            end else if (sh_out_valid) begin
                acc <= acc ^ sh_out_data;
            end

            if (drain_done) begin
                row_if.row_valid <= 1'b1;
                row_if.row_data  <= acc;
                row_if.row_idx   <= row;
            end
        end
    end
endmodule

// File: tb/tb_qc_row_shift_scheduler.sv
// Self-checking bench for qc_row_shift_scheduler: NB=4, MB=2, MAXZ=81 with a
// behavioural pipelined circular shifter (rotate right within z) whose output
// tap is normally stage 7. Expected row results are hand-computed and queued
// before each pass; a monitor pops and compares on every accepted row.
module tb_qc_row_shift_scheduler;
    localparam int MAXZ   = 81;
    localparam int NB     = 4;
    localparam int MB     = 2;
    localparam int SW     = $clog2(MAXZ);
    localparam int AW     = $clog2(MB * NB);
    localparam int CW     = $clog2(NB);
    localparam int LATMAX = 7;

    logic            CLK = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [SW:0]     z_size = 8'd81;
    logic            busy, done, err;
    logic [AW-1:0]   bm_addr;
    logic [SW:0]     bm_rdata = '0;
    logic [CW-1:0]   blk_addr;
    logic [MAXZ-1:0] blk_rdata = '0;
    logic            sh_valid;
    logic [MAXZ-1:0] sh_data;
    logic [SW-1:0]   sh_shift;
    logic            sh_out_valid;
    logic [MAXZ-1:0] sh_out_data;

    qc_row_shift_scheduler_if #(.MAXZ(MAXZ), .MB(MB)) rif ();

    qc_row_shift_scheduler #(.MAXZ(MAXZ), .NB(NB), .MB(MB)) dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .start        (start),
        .z_size       (z_size),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .bm_addr      (bm_addr),
        .bm_rdata     (bm_rdata),
        .blk_addr     (blk_addr),
        .blk_rdata    (blk_rdata),
        .sh_valid     (sh_valid),
        .sh_data      (sh_data),
        .sh_shift     (sh_shift),
        .sh_out_valid (sh_out_valid),
        .sh_out_data  (sh_out_data),
        .row_if       (rif)
    );

    always #5 CLK = ~CLK;

    // Base-matrix and data-block memories, one-cycle read latency.
    logic [SW:0]     bm_mem  [MB*NB];
    logic [MAXZ-1:0] blk_mem [NB];
    always @(posedge CLK) begin
        bm_rdata  <= bm_mem[bm_addr];
        blk_rdata <= blk_mem[blk_addr];
    end

    // Circular shifter model: rotate right by s within the low z bits.
    int                z_cur = 81;
    int                tap = LATMAX;
    logic [LATMAX-1:0] pv = '0;
    logic [MAXZ-1:0]   pd [LATMAX];

    function automatic logic [MAXZ-1:0] rot(input logic [MAXZ-1:0] d, input int s, input int z);
        logic [MAXZ-1:0] r;
        r = '0;
        for (int i = 0; i < z; i++) r[i] = d[(i + s) % z];
        return r;
    endfunction

    initial for (int k = 0; k < LATMAX; k++) pd[k] = '0;

    always @(posedge CLK) begin
        pv[0] <= sh_valid;
        pd[0] <= sh_valid ? rot(sh_data, int'(sh_shift), z_cur) : '0;
        for (int k = 1; k < LATMAX; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
    end
    assign sh_out_valid = pv[tap-1];
    assign sh_out_data  = pd[tap-1];

    // Scoreboard.
    typedef struct {
        logic            idx;
        logic [MAXZ-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [MAXZ-1:0] act, input logic [MAXZ-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic idx, input logic [MAXZ-1:0] d);
        exp_t e;
        e.idx  = idx;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every accepted row result against the queue head.
    always @(negedge CLK) begin
        if (rst_n && rif.row_valid && rif.row_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_row", 81'(1), 81'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("row_idx", 81'(rif.row_idx), 81'(e.idx));
                check("row_data", rif.row_data, e.data);
            end
        end
    end

    // Shifter-port protocol observation.
    int sh_count = 0;
    int zero_viol = 0;
    int outside_viol = 0;
    int conc = 0;
    always @(negedge CLK) begin
        if (rst_n) begin
            if (sh_valid) sh_count++;
            if (!sh_valid && (sh_data != '0 || sh_shift != '0)) zero_viol++;
            if (sh_valid && !busy) outside_viol++;
            if (sh_valid && sh_out_valid) conc++;
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic pulse_start(input logic [SW:0] z);
        z_size = z;
        z_cur  = int'(z);
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic wait_done(output logic e);
        int n = 0;
        while (!done && n < 400) begin
            step();
            n++;
        end
        check("done_seen", 81'(done), 81'(1));
        e = err;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 81'({busy, done, err, bm_addr, blk_addr, sh_valid, sh_shift,
                                   rif.row_valid, rif.row_idx}), 81'(0));
        check({tag, "_sh_data"}, sh_data, '0);
        check({tag, "_row_data"}, rif.row_data, '0);
    endtask

    task automatic clear_mems();
        for (int i = 0; i < MB*NB; i++) bm_mem[i] = '0;
        for (int i = 0; i < NB; i++) blk_mem[i] = '0;
    endtask

    // Row0: {v,1},{null},{v,0},{null}; row1 all null.
    task automatic load_a();
        clear_mems();
        bm_mem[0]  = 8'h81;
        bm_mem[2]  = 8'h80;
        blk_mem[0] = 81'h1;
        blk_mem[1] = 81'h1234;
        blk_mem[2] = 81'h2;
        blk_mem[3] = 81'h55;
    endtask

    localparam logic [MAXZ-1:0] EXP_A0 = (81'(1) << 80) | 81'(2);

    initial begin
        logic e;
        int   n;
        int   sh_mark;

        clear_mems();
        rif.row_ready = 1'b0;
        #3;
        check_all_zero("reset");
        step();
        rst_n = 1'b1;
        step();

        // Pass A: hold test, ignored start, null-row timing, done/busy timing.
        load_a();
        push_exp(1'b0, EXP_A0);
        push_exp(1'b1, '0);
        pulse_start(8'd81);
        check("busy_after_start", 81'(busy), 81'(1));
        z_size = 8'd1;             // would flag err on shift 1 if sampled
        start  = 1'b1;
        step();
        start  = 1'b0;
        z_size = 8'd81;
        n = 0;
        while (!rif.row_valid && n < 100) begin
            step();
            n++;
        end
        check("row0_valid_seen", 81'(rif.row_valid), 81'(1));
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", 81'(rif.row_valid), 81'(1));
            check("hold_data", rif.row_data, EXP_A0);
            check("hold_idx", 81'(rif.row_idx), 81'(0));
            check("hold_bm_addr_sh", 81'({bm_addr, sh_valid}), 81'(0));
        end
        rif.row_ready = 1'b1;
        step();
        check("valid_drop_after_accept", 81'(rif.row_valid), 81'(0));
        check("next_row_bm_addr", 81'(bm_addr), 81'(4));
        sh_mark = sh_count;
        n = 0;
        while (!rif.row_valid && n < 50) begin
            step();
            n++;
        end
        check("null_row_latency", 81'(n), 81'(6));
        check("null_row_no_issue", 81'(sh_count - sh_mark), 81'(0));
        step();
        check("done_after_accept", 81'({done, busy}), 81'(2'b10));
        step();
        check("done_one_cycle", 81'({done, busy}), 81'(2'b00));
        check("ignored_start_no_err", 81'(err), 81'(0));

        // Pass B: z=64, {v,70} flags err; {v,5} on 0x3 gives 3<<59.
        clear_mems();
        bm_mem[0]  = 8'hC6;
        bm_mem[1]  = 8'h85;
        blk_mem[0] = 81'hAB;
        blk_mem[1] = 81'h3;
        push_exp(1'b0, 81'(3) << 59);
        push_exp(1'b1, '0);
        pulse_start(8'd64);
        wait_done(e);
        check("err_sticky_at_done", 81'(e), 81'(1));
        step();
        check("err_after_done", 81'(err), 81'(1));

        // Pass C: shortened shifter tap so issue and return overlap.
        // Row0: two {v,3} on 0xF0 cancel; row1: {v,2} on 0xF0 gives 0x3C.
        clear_mems();
        bm_mem[0]  = 8'h83;
        bm_mem[1]  = 8'h83;
        bm_mem[4]  = 8'h82;
        blk_mem[0] = 81'hF0;
        blk_mem[1] = 81'hF0;
        tap = 1;
        push_exp(1'b0, '0);
        push_exp(1'b1, 81'h3C);
        pulse_start(8'd81);
        check("start_clears_err", 81'(err), 81'(0));
        wait_done(e);
        check("pass_c_err", 81'(e), 81'(0));
        check("concurrent_seen", 81'(conc > 0), 81'(1));
        step();
        tap = LATMAX;

        // Pass D: reset in the middle of ISSUE, then a clean pass.
        load_a();
        pulse_start(8'd81);
        step();
        step();
        check("busy_before_reset", 81'(busy), 81'(1));
        #1 rst_n = 1'b0;
        #1 check_all_zero("mid_reset");
        step();
        step();
        rst_n = 1'b1;
        repeat (12) step();
        push_exp(1'b0, EXP_A0);
        push_exp(1'b1, '0);
        pulse_start(8'd81);
        wait_done(e);
        check("pass_d_err", 81'(e), 81'(0));
        step();

        check("scoreboard_empty", 81'(exp_q.size()), 81'(0));
        check("sh_zero_when_idle", 81'(zero_viol), 81'(0));
        check("sh_valid_only_busy", 81'(outside_viol), 81'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/qc_row_shift_scheduler.md
Name: qc_row_shift_scheduler

Overview:
- Row-by-row sequencer for the pipelined circular shifter in the QC-LDPC datapath.
- For each base-matrix row it walks all block columns and fetches the base-matrix entry and the Z-bit data block.
- For every non-null circulant it issues data plus shift value to the shifter, and XOR-accumulates the shifter outputs.
- It emits one Z-bit row result per row over a valid/ready handshake.

Parameters:
- MAXZ, 81, maximum lifting size; width of data blocks and shifter.
- NB, 24, number of block columns per base-matrix row.
- MB, 12, number of base-matrix rows.
- SW (localparam), $clog2(MAXZ), shift-value width.

Ports:
- CLK  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset; clears all state immediately.
- start  in  1  one-cycle pulse; begins a full MB-row pass. Sampled only in IDLE.
- z_size  in  SW+1  active lifting size; sampled on accepted start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last row is accepted.
- err  out  1  sticky flag: an entry had shift >= z_size. Cleared on accepted start.
- bm_addr  out  $clog2(MB*NB)  base-matrix read address = row*NB+col. Read latency is 1 cycle.
- bm_rdata  in  SW+1  entry: [SW] = 1 means non-null circulant; [SW-1:0] = shift.
- blk_addr  out  $clog2(NB)  data-block read address = col. Read latency is 1 cycle.
- blk_rdata  in  MAXZ  data block; already zero-padded upstream.
- sh_valid  out  1  issue strobe to the shifter (valid_in).
- sh_data  out  MAXZ  shifter in_data.
- sh_shift  out  SW  shifter shift_val.
- sh_out_valid  in  1  shifter valid_out.
- sh_out_data  in  MAXZ  shifter out_data.
- row_valid  out  1  row result available.
- row_ready  in  1  consumer accepts the row result.
- row_idx  out  $clog2(MB)  row index of row_data.
- row_data  out  MAXZ  XOR of all shifted blocks in the row.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters 0; accumulator 0.
- FSM states: IDLE, ISSUE, DRAIN, OUT, DONE.
- IDLE: on start, latch z_size, clear err, set row = 0, col = 0, clear accumulator, go to ISSUE. Otherwise start is ignored (including while busy).
- ISSUE:
  - Drive bm_addr = row*NB+col and blk_addr = col, and increment col, for NB consecutive cycles.
  - A registered "pending" flag marks that read data returns next cycle.
  - When the returned entry is valid and its shift < z_size: sh_valid = 1, sh_data = blk_rdata, sh_shift = entry shift (same cycle as the data return).
  - When the entry is valid and shift >= z_size: no issue, and err is set.
  - When the entry is null: no issue.
  - Leave ISSUE the cycle after the last column's data returns (NB+1 cycles total). Go to DRAIN.
- In-flight counter (width $clog2(NB+1)):
  - Increments on sh_valid and decrements on sh_out_valid.
  - When both occur in the same cycle, the count is unchanged.
- Accumulator: acc <= acc ^ sh_out_data on every sh_out_valid, in any state.
- DRAIN: wait until in-flight = 0 with no sh_out_valid in that cycle. Then register row_data = acc, row_idx = row, row_valid = 1, and go to OUT. If the row issued nothing, DRAIN lasts exactly 1 cycle.
- OUT:
  - Hold row_valid, row_data and row_idx stable until row_ready.
  - On row_valid && row_ready: drop row_valid next cycle and clear the accumulator.
  - If row < MB-1: row++, col = 0, go to ISSUE. Otherwise go to DONE.
  - No base-matrix or block reads occur in OUT.
- DONE: pulse done for 1 cycle, drop busy, go to IDLE.
- sh_valid is never asserted outside ISSUE. sh_data and sh_shift are 0 whenever sh_valid = 0.
- Asynchronous reset mid-operation aborts the pass. In-flight shifter outputs after reset are ignored, because the accumulator is cleared on row start.

Test Plan:
- MAXZ=81, NB=4, MB=2, real 7-stage shifter attached. Row0 entries {v,1},{null},{v,0},{null}; blk0 = 0x1, blk2 = 0x2 -> row_idx 0, row_data = (1<<80)|0x2, row_valid exactly once.
- Row1 all null -> row_idx 1, row_data = 0, no sh_valid during the row, DRAIN lasts 1 cycle, done pulses 1 cycle after acceptance, busy falls with done.
- Hold row_ready low for 5 cycles with row_valid high -> row_data and row_idx stable, bm_addr static, no sh_valid; accept -> next row begins ISSUE the following cycle.
- z_size = 64, entry {v,70} -> no issue for that column, err = 1 and stays 1 through done; next start clears err.
- Row with two identical entries (shift 3, same blk data 0xF0) -> the two results cancel, row_data = 0. Exercise concurrent sh_valid/sh_out_valid and check the in-flight count never underflows.
- Assert rst_n low in the middle of ISSUE -> all outputs 0 immediately. Pulse start while busy -> ignored. Fresh start after reset -> correct results for both rows.
